// File: rtl/display_snapshot_controller.sv
// Snapshot sequencer and pixel-to-bit lookup for the CPU debug display.
// Optional watchdog on stalled fetches: define SNAPSHOT_TIMEOUT_EN (adds timeout_out).
`timescale 1ns/1ps
module display_snapshot_controller #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ROWS   = 10
) (
  input  logic              clock_in,
  input  logic              reset_n_in,
  input  logic              frame_start_in,
  input  logic [9:0]        pixel_x_in,
  input  logic [9:0]        pixel_y_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] ir_in,
  input  logic [DATA_W-1:0] acc_in,
  input  logic [ADDR_W-1:0] data_base_in,
  output logic              mem_req_out,
  output logic              mem_sel_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_grant_in,
  input  logic              mem_valid_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              bit_value_out,
  output logic              busy_out,
  output logic              overrun_out
`ifdef SNAPSHOT_TIMEOUT_EN
  ,
  output logic              timeout_out
`endif
);

  localparam int unsigned K_W = $clog2(ROWS);
  localparam int unsigned C_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, LATCH, REQ, WAIT_DATA, COMMIT} state_t;
  typedef enum logic [2:0] {F_NONE, F_IADDR, F_IWORD, F_DADDR, F_DWORD, F_PC, F_IR, F_ACC} field_t;

  state_t state, nxt;

  logic [K_W-1:0]    k, k_d;
  logic [ADDR_W-1:0] base, base_d;
  logic              sel_d, stale, stale_d, ovr_d, wr_en, adv;
  logic [DATA_W-1:0] wr_data;

  logic [ADDR_W-1:0] pc_lat, dbase_lat, disp_pc, disp_dbase;
  logic [DATA_W-1:0] ir_lat, acc_lat, disp_ir, disp_acc;
  logic [DATA_W-1:0] shadow    [2][ROWS];
  logic [DATA_W-1:0] disp_word [2][ROWS];

`ifdef SNAPSHOT_TIMEOUT_EN
  logic [7:0] wdog;
  logic       tmo_d;
`endif

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= nxt;
  end

  // Next-state, fetch bookkeeping and overrun handling
  always_comb begin
    nxt     = state;
    k_d     = k;
    sel_d   = mem_sel_out;
    base_d  = base;
    stale_d = stale;
    ovr_d   = overrun_out;
    wr_en   = 1'b0;
    wr_data = mem_data_in;
    adv     = 1'b0;
`ifdef SNAPSHOT_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    if (stale && mem_valid_in) stale_d = 1'b0;
    unique case (state)
      IDLE:      if (frame_start_in) nxt = LATCH;
      LATCH: begin
        nxt    = REQ;
        k_d    = '0;
        sel_d  = 1'b0;
        base_d = pc_in;
      end
      REQ:       if (mem_grant_in && mem_req_out) nxt = WAIT_DATA;
      WAIT_DATA: if (mem_valid_in && !stale) begin
        wr_en = 1'b1;
        adv   = 1'b1;
      end
      COMMIT:    nxt = IDLE;
      default:   nxt = IDLE;
    endcase
`ifdef SNAPSHOT_TIMEOUT_EN
    if ((state == REQ || state == WAIT_DATA) && wdog == 8'hFF) begin
      wr_en   = 1'b1;
      wr_data = '0;
      adv     = 1'b1;
      tmo_d   = 1'b1;
    end
`endif
    if (adv) begin
      if (k < K_W'(ROWS - 1)) begin
        k_d = k + K_W'(1);
        nxt = REQ;
      end else if (!mem_sel_out) begin
        sel_d  = 1'b1;
        k_d    = '0;
        base_d = dbase_lat;
        nxt    = REQ;
      end else begin
        nxt = COMMIT;
      end
    end
    // A late frame start abandons the fetch; an in-flight read must be swallowed
    if (frame_start_in && state != IDLE) begin
      nxt     = LATCH;
      ovr_d   = 1'b1;
      wr_en   = 1'b0;
      stale_d = stale_d | ((state == WAIT_DATA) && !mem_valid_in)
                        | ((state == REQ) && mem_grant_in && mem_req_out);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      k            <= '0;
      base         <= '0;
      stale        <= 1'b0;
      mem_sel_out  <= 1'b0;
      mem_req_out  <= 1'b0;
      mem_addr_out <= '0;
      busy_out     <= 1'b0;
      overrun_out  <= 1'b0;
    end else begin
      k            <= k_d;
      base         <= base_d;
      stale        <= stale_d;
      mem_sel_out  <= sel_d;
`ifdef SNAPSHOT_TIMEOUT_EN
      mem_req_out  <= (nxt == REQ) && !tmo_d;
`else
      mem_req_out  <= (nxt == REQ);
`endif
      mem_addr_out <= ADDR_W'(base_d + ADDR_W'(k_d));
      busy_out     <= (nxt != IDLE);
      overrun_out  <= ovr_d;
    end
  end

`ifdef SNAPSHOT_TIMEOUT_EN
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wdog        <= '0;
      timeout_out <= 1'b0;
    end else begin
      timeout_out <= tmo_d;
      if (nxt != state || tmo_d)                    wdog <= '0;
      else if (state == REQ || state == WAIT_DATA) wdog <= wdog + 8'd1;
    end
  end
`endif

  // Register latch, shadow fill and atomic commit to the display copy
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pc_lat     <= '0;
      dbase_lat  <= '0;
      ir_lat     <= '0;
      acc_lat    <= '0;
      disp_pc    <= '0;
      disp_dbase <= '0;
      disp_ir    <= '0;
      disp_acc   <= '0;
      for (int s = 0; s < 2; s++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          shadow[s][r]    <= '0;
          disp_word[s][r] <= '0;
        end
      end
    end else begin
      if (state == LATCH) begin
        pc_lat    <= pc_in;
        dbase_lat <= data_base_in;
        ir_lat    <= ir_in;
        acc_lat   <= acc_in;
      end
      if (wr_en) shadow[mem_sel_out][k] <= wr_data;
      if (state == COMMIT) begin
        disp_pc    <= pc_lat;
        disp_dbase <= dbase_lat;
        disp_ir    <= ir_lat;
        disp_acc   <= acc_lat;
        disp_word  <= shadow;
      end
    end
  end

  function automatic logic in_box(input logic [9:0] x, input logic [9:0] y,
                                  input logic [9:0] x0, input logic [9:0] x1,
                                  input logic [9:0] y0, input logic [9:0] y1);
    return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
  endfunction

  field_t            fld;
  logic [9:0]        ox, oy;
  logic [C_W-1:0]    col;
  logic [K_W-1:0]    row;
  logic [DATA_W-1:0] word;
  logic              pix_d;

  // Pixel coordinate to field, character column and text row
  always_comb begin
    fld = F_NONE;
    ox  = '0;
    oy  = '0;
    if      (in_box(pixel_x_in, pixel_y_in, 10'd16,  10'd143, 10'd48,  10'd207)) begin fld = F_IADDR; ox = 10'd16;  oy = 10'd48;  end
    else if (in_box(pixel_x_in, pixel_y_in, 10'd160, 10'd287, 10'd48,  10'd207)) begin fld = F_IWORD; ox = 10'd160; oy = 10'd48;  end
    else if (in_box(pixel_x_in, pixel_y_in, 10'd16,  10'd143, 10'd304, 10'd463)) begin fld = F_DADDR; ox = 10'd16;  oy = 10'd304; end
    else if (in_box(pixel_x_in, pixel_y_in, 10'd160, 10'd287, 10'd304, 10'd463)) begin fld = F_DWORD; ox = 10'd160; oy = 10'd304; end
    else if (in_box(pixel_x_in, pixel_y_in, 10'd357, 10'd484, 10'd65,  10'd80))  begin fld = F_PC;    ox = 10'd357; oy = 10'd65;  end
    else if (in_box(pixel_x_in, pixel_y_in, 10'd357, 10'd484, 10'd165, 10'd180)) begin fld = F_IR;    ox = 10'd357; oy = 10'd165; end
    else if (in_box(pixel_x_in, pixel_y_in, 10'd503, 10'd630, 10'd165, 10'd180)) begin fld = F_ACC;   ox = 10'd503; oy = 10'd165; end
    col = C_W'((pixel_x_in - ox) >> 3);
    row = K_W'((pixel_y_in - oy) >> 4);
    unique case (fld)
      F_IADDR: word = DATA_W'(ADDR_W'(disp_pc + ADDR_W'(row)));
      F_IWORD: word = disp_word[0][row];
      F_DADDR: word = DATA_W'(ADDR_W'(disp_dbase + ADDR_W'(row)));
      F_DWORD: word = disp_word[1][row];
      F_PC:    word = DATA_W'(disp_pc);
      F_IR:    word = disp_ir;
      F_ACC:   word = disp_acc;
      default: word = '0;
    endcase
    pix_d = (fld != F_NONE) && word[C_W'(DATA_W - 1) - col];
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) bit_value_out <= 1'b0;
    else             bit_value_out <= pix_d;
  end

endmodule

// File: tb/tb_display_snapshot_controller.sv
// Scoreboard bench for display_snapshot_controller: expected fetches and probes are
// queued by the stimulus and checked by independent monitors.
`timescale 1ns/1ps
module tb_display_snapshot_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic [7:0] pc = '0, data_base = '0;
  logic [15:0] ir = 16'h1234, acc = 16'h8001;
  logic       mem_req, mem_sel, mem_grant = 1'b0, mem_valid = 1'b0;
  logic [7:0] mem_addr;
  logic [15:0] mem_data = '0;
  logic       bit_value, busy, overrun;
`ifdef SNAPSHOT_TIMEOUT_EN
  logic       timeout;
`endif

  display_snapshot_controller dut (
    .clock_in(clk), .reset_n_in(rst_n), .frame_start_in(frame_start),
    .pixel_x_in(pixel_x), .pixel_y_in(pixel_y),
    .pc_in(pc), .ir_in(ir), .acc_in(acc), .data_base_in(data_base),
    .mem_req_out(mem_req), .mem_sel_out(mem_sel), .mem_addr_out(mem_addr),
    .mem_grant_in(mem_grant), .mem_valid_in(mem_valid), .mem_data_in(mem_data),
    .bit_value_out(bit_value), .busy_out(busy), .overrun_out(overrun)
`ifdef SNAPSHOT_TIMEOUT_EN
    , .timeout_out(timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [15:0] exp; string name; } chk_t;
  typedef struct { logic sel; logic [7:0] addr; } req_t;
  chk_t chk_q[$];
  req_t req_q[$];

  int   n_vec = 0, n_miss = 0, n_grant = 0, grant_limit = 1 << 30;
  logic probe = 1'b0, probe_q = 1'b0;
  logic pend = 1'b0, pend_sel = 1'b0;
  logic [7:0] pend_addr = '0;

  always @(posedge clk) probe_q <= probe;

  // Probe monitor: kind 0 pixel bit, 1 busy, 2 overrun, 3 {req,addr}, 4 req
  always @(negedge clk) begin
    chk_t c;
    logic [15:0] got;
    if (probe_q) begin
      n_vec++;
      if (chk_q.size() == 0) begin
        n_miss++;
        $display("FAIL probe_queue got empty required entry");
      end else begin
        c = chk_q.pop_front();
        case (c.kind)
          0:       got = {15'b0, bit_value};
          1:       got = {15'b0, busy};
          2:       got = {15'b0, overrun};
          3:       got = {7'b0, mem_req, mem_addr};
          default: got = {15'b0, mem_req};
        endcase
        if (got !== c.exp) begin
          n_miss++;
          $display("FAIL %s got %h required %h", c.name, got, c.exp);
        end
      end
    end
  end

  // Memory model and request monitor: grant at most grant_limit, data one cycle later
  always @(negedge clk) begin
    req_t r;
    mem_valid = 1'b0;
    if (pend) begin
      mem_valid = 1'b1;
      mem_data  = pend_sel ? {8'hA5, pend_addr} : {8'h00, pend_addr};
      pend      = 1'b0;
    end
    mem_grant = 1'b0;
    if (mem_req && n_grant < grant_limit) begin
      mem_grant = 1'b1;
      n_grant++;
      pend      = 1'b1;
      pend_addr = mem_addr;
      pend_sel  = mem_sel;
      n_vec++;
      if (req_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_request got sel=%0d addr=%h required none", mem_sel, mem_addr);
      end else begin
        r = req_q.pop_front();
        if (r.sel !== mem_sel || r.addr !== mem_addr) begin
          n_miss++;
          $display("FAIL request got sel=%0d addr=%h required sel=%0d addr=%h",
                   mem_sel, mem_addr, r.sel, r.addr);
        end
      end
    end
  end

  task automatic chk(input int kind, input logic [15:0] exp, input string name,
                     input logic [9:0] x = 10'd0, input logic [9:0] y = 10'd0);
    @(negedge clk);
    pixel_x = x;
    pixel_y = y;
    chk_q.push_back('{kind, exp, name});
    probe = 1'b1;
    @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic push_reqs(input logic sel, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) req_q.push_back('{sel, 8'(first + 8'(i))});
  endtask

  task automatic start_frame(input logic [7:0] p, input logic [7:0] db);
    pc = p;
    data_base = db;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (busy && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (busy) begin
      n_miss++;
      $display("FAIL %s_timeout got busy=1 required busy=0", name);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and blank display
    chk(1, 16'h0, "reset_busy");
    chk(2, 16'h0, "reset_overrun");
    chk(4, 16'h0, "reset_req");
    chk(0, 16'h0, "blank_16_48", 10'd16, 10'd48);

    // Frame 1: pc 0x05, data window 0x40
    push_reqs(1'b0, 8'h05, 10);
    push_reqs(1'b1, 8'h40, 10);
    start_frame(8'h05, 8'h40);
    wait_idle("frame1");
    chk(0, 16'h1, "iaddr_r0_b2", 10'd120, 10'd48);
    chk(0, 16'h0, "iaddr_r0_b1", 10'd128, 10'd48);
    chk(0, 16'h1, "iaddr_r9_b1", 10'd128, 10'd192);
    chk(0, 16'h0, "iaddr_r0_b15", 10'd16, 10'd48);
    chk(0, 16'h1, "iword_r0_b2", 10'd264, 10'd48);
    chk(0, 16'h1, "dword_r9_b15", 10'd160, 10'd448);
    chk(0, 16'h0, "dword_r9_b14", 10'd168, 10'd448);
    chk(0, 16'h1, "daddr_r9_b6", 10'd88, 10'd448);
    chk(0, 16'h1, "pc_b2", 10'd461, 10'd65);
    chk(0, 16'h0, "pc_b1", 10'd469, 10'd80);
    chk(0, 16'h1, "ir_b12", 10'd381, 10'd165);
    chk(0, 16'h0, "ir_b15", 10'd357, 10'd180);
    chk(0, 16'h1, "acc_b15", 10'd503, 10'd165);
    chk(0, 16'h0, "acc_b14", 10'd511, 10'd165);
    chk(0, 16'h1, "acc_b0", 10'd623, 10'd165);
    chk(0, 16'h1, "acc_corner", 10'd630, 10'd180);
    chk(0, 16'h0, "outside_300_100", 10'd300, 10'd100);
    chk(0, 16'h0, "left_of_iaddr", 10'd15, 10'd48);
    chk(0, 16'h0, "right_of_iaddr", 10'd144, 10'd48);
    chk(0, 16'h0, "below_iaddr", 10'd16, 10'd208);
    chk(2, 16'h0, "frame1_overrun");
    chk(1, 16'h0, "frame1_idle");

    // Frame 2: address wrap, with the port withheld first
    grant_limit = n_grant;
    push_reqs(1'b0, 8'hFB, 10);
    push_reqs(1'b1, 8'hFE, 10);
    start_frame(8'hFB, 8'hFE);
    @(negedge clk);
    for (int i = 0; i < 50; i++) chk(3, {7'b0, 1'b1, 8'hFB}, "req_stable");
    grant_limit = 1 << 30;
    wait_idle("frame2");
    chk(0, 16'h1, "wrap_iaddr_r4_b7", 10'd80, 10'd112);
    chk(0, 16'h0, "wrap_iaddr_r5_b7", 10'd80, 10'd128);
    chk(0, 16'h1, "wrap_iword_r4_b7", 10'd224, 10'd112);
    chk(0, 16'h0, "wrap_daddr_r2_b7", 10'd80, 10'd336);
    chk(0, 16'h1, "wrap_dword_r1_b15", 10'd160, 10'd320);

    // Overrun: seven words then a fresh frame start
    grant_limit = n_grant + 7;
    push_reqs(1'b0, 8'h20, 7);
    start_frame(8'h20, 8'h30);
    repeat (30) @(negedge clk);
    chk(1, 16'h1, "stalled_busy");
    chk(0, 16'h1, "old_frame_kept", 10'd80, 10'd112);
    push_reqs(1'b0, 8'h60, 10);
    push_reqs(1'b1, 8'h70, 10);
    start_frame(8'h60, 8'h70);
    grant_limit = 1 << 30;
    chk(2, 16'h1, "overrun_set");
    chk(0, 16'h1, "old_frame_during_refetch", 10'd80, 10'd112);
    wait_idle("frame3");
    chk(0, 16'h0, "new_iaddr_r4_b7", 10'd80, 10'd112);
    chk(0, 16'h1, "new_iaddr_r0_b6", 10'd88, 10'd48);
    chk(0, 16'h1, "new_dword_r0_b15", 10'd160, 10'd304);
    chk(0, 16'h0, "new_dword_r0_b14", 10'd168, 10'd304);
    chk(2, 16'h1, "overrun_sticky");

    // Reset while a read is outstanding
    grant_limit = n_grant + 3;
    push_reqs(1'b0, 8'h10, 3);
    start_frame(8'h10, 8'h50);
    begin
      int cyc = 0;
      while (n_grant < grant_limit && cyc < 200) begin
        @(posedge clk);
        cyc++;
      end
      n_vec++;
      if (n_grant < grant_limit) begin
        n_miss++;
        $display("FAIL grant_wait got %0d grants required %0d", n_grant, grant_limit);
      end
    end
    #1 rst_n = 1'b0;
    chk(4, 16'h0, "req_after_reset");
    chk(1, 16'h0, "busy_after_reset");
    chk(2, 16'h0, "overrun_after_reset");
    chk(0, 16'h0, "acc_after_reset", 10'd623, 10'd165);
    chk(0, 16'h0, "iaddr_after_reset", 10'd88, 10'd48);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    n_vec++;
    if (req_q.size() != 0 || chk_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover_expectations got req=%0d probe=%0d required 0 0",
               req_q.size(), chk_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
